// File: rtl/loop_track_ctrl_pkg.sv
// Shared types and helpers for the multi-track loop recorder controller.
package loop_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC1 = 2'd1,
        S_PLAY = 2'd2,
        S_ODUB = 2'd3
    } state_t;

    // Track-index width; never narrower than one bit so a single-track build still has a select line.
    function automatic int trk_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loop_track_ctrl_if.sv
// Button/RAM-side signal bundle of the loop recorder controller.
interface loop_track_ctrl_if
    import loop_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int ADDR_W     = 14
);
    localparam int TRK_W = trk_w(NUM_TRACKS);

    logic                  sample_tick;
    logic                  rec_btn;
    logic                  play_btn;
    logic                  clear_btn;
    logic [TRK_W-1:0]      trk_sel;
    logic [ADDR_W-1:0]     addr;
    logic                  wr_en;
    logic [TRK_W-1:0]      wr_trk;
    logic                  rd_en;
    logic [NUM_TRACKS-1:0] trk_valid;
    logic [ADDR_W-1:0]     loop_end;
    logic                  len_valid;
    logic                  wrap;
    logic                  led_rec;
    logic                  led_play;

    modport master (
        output sample_tick, rec_btn, play_btn, clear_btn, trk_sel,
        input  addr, wr_en, wr_trk, rd_en, trk_valid, loop_end, len_valid,
               wrap, led_rec, led_play
    );

    modport slave (
        input  sample_tick, rec_btn, play_btn, clear_btn, trk_sel,
        output addr, wr_en, wr_trk, rd_en, trk_valid, loop_end, len_valid,
               wrap, led_rec, led_play
    );

endinterface

// File: rtl/loop_track_ctrl_addr_ctr.sv
// Shared sample-address counter: free-running during the first take, wrapping at the loop end during playback.
module loop_addr_ctr #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_clr,
    input  logic              i_wrap_en,
    input  logic [ADDR_W-1:0] i_end,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wrap
);

    logic [ADDR_W-1:0] r_addr;
    logic              w_at_end;

    assign w_at_end = (r_addr == i_end);
    assign o_wrap   = i_tick & i_wrap_en & w_at_end;
    assign o_addr   = r_addr;

    // Clear wins over stepping; without wrap enable the count rolls over naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= {ADDR_W{1'b0}};
        end else if (i_clr) begin
            r_addr <= {ADDR_W{1'b0}};
        end else if (i_tick) begin
            if (i_wrap_en && w_at_end) begin
                r_addr <= {ADDR_W{1'b0}};
            end else begin
                r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/loop_track_ctrl.sv
// Multi-track loop recorder mode controller (rec / play / overdub / clear).
// Optional LOOP_QUANT_EN: overdub requested during playback starts at the next loop wrap.
module loop_track_ctrl
    import loop_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int ADDR_W     = 14
) (
    input  logic               clk,
    input  logic               rst,
    loop_track_ctrl_if.slave   bus
);

    localparam int TRK_W = trk_w(NUM_TRACKS);
    localparam logic [NUM_TRACKS-1:0] TRK_ONE = NUM_TRACKS'(1);

    state_t                r_state;
    logic [ADDR_W-1:0]     r_loop_end;
    logic                  r_len_valid;
    logic [NUM_TRACKS-1:0] r_trk_valid;
    logic [TRK_W-1:0]      r_wr_trk;
    logic                  r_led_rec;
    logic                  r_led_play;
`ifdef LOOP_QUANT_EN
    logic                  r_armed;
`endif

    logic                  w_tick;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_wrap;
    logic                  w_wrap_en;
    logic                  w_clr;
    logic                  w_rec1_done;
    logic [ADDR_W:0]       w_count;
    logic [ADDR_W:0]       w_last;
    logic [NUM_TRACKS-1:0] w_trk_bit;

    assign w_tick = bus.sample_tick;

    loop_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (w_tick),
        .i_clr     (w_clr),
        .i_wrap_en (w_wrap_en),
        .i_end     (r_loop_end),
        .o_addr    (w_addr),
        .o_wrap    (w_wrap)
    );

    // First-take close detection and address-clear conditions; a tick in the closing cycle still counts.
    always_comb begin
        w_wrap_en   = (r_state == S_PLAY) || (r_state == S_ODUB);
        w_count     = {1'b0, w_addr} + {{ADDR_W{1'b0}}, w_tick};
        w_last      = w_count - {{ADDR_W{1'b0}}, 1'b1};
        w_rec1_done = (r_state == S_REC1) &&
                      (bus.rec_btn || bus.play_btn ||
                       (w_tick && (w_addr == {ADDR_W{1'b1}})));
        w_trk_bit   = TRK_ONE << r_wr_trk;
        w_clr       = (r_state == S_IDLE) || w_rec1_done ||
                      (w_wrap_en && bus.play_btn);
    end

    assign bus.addr      = w_addr;
    assign bus.wr_en     = w_tick && ((r_state == S_REC1) || (r_state == S_ODUB));
    assign bus.rd_en     = w_tick && w_wrap_en;
    assign bus.wrap      = w_wrap;
    assign bus.wr_trk    = r_wr_trk;
    assign bus.trk_valid = r_trk_valid;
    assign bus.loop_end  = r_loop_end;
    assign bus.len_valid = r_len_valid;
    assign bus.led_rec   = r_led_rec;
    assign bus.led_play  = r_led_play;

    // Mode FSM with loop bookkeeping; LEDs are registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_loop_end  <= {ADDR_W{1'b0}};
            r_len_valid <= 1'b0;
            r_trk_valid <= {NUM_TRACKS{1'b0}};
            r_wr_trk    <= {TRK_W{1'b0}};
            r_led_rec   <= 1'b0;
            r_led_play  <= 1'b0;
`ifdef LOOP_QUANT_EN
            r_armed     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clear_btn) begin
                        r_len_valid <= 1'b0;
                        r_trk_valid <= {NUM_TRACKS{1'b0}};
                        r_loop_end  <= {ADDR_W{1'b0}};
                    end else if (bus.play_btn) begin
                        if (r_len_valid) begin
                            r_state    <= S_PLAY;
                            r_led_play <= 1'b1;
                        end
                    end else if (bus.rec_btn) begin
                        r_wr_trk   <= bus.trk_sel;
                        r_state    <= r_len_valid ? S_ODUB : S_REC1;
                        r_led_rec  <= 1'b1;
                        r_led_play <= r_len_valid;
                    end
                end
                S_REC1: begin
                    if (w_rec1_done) begin
                        r_led_rec <= 1'b0;
                        if (w_count == {(ADDR_W+1){1'b0}}) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_loop_end  <= w_last[ADDR_W-1:0];
                            r_len_valid <= 1'b1;
                            r_trk_valid <= r_trk_valid | w_trk_bit;
                            r_state     <= S_PLAY;
                            r_led_play  <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (bus.play_btn) begin
                        r_state    <= S_IDLE;
                        r_led_play <= 1'b0;
`ifdef LOOP_QUANT_EN
                        r_armed    <= 1'b0;
                    end else if (bus.rec_btn) begin
                        r_armed  <= ~r_armed;
                        r_wr_trk <= bus.trk_sel;
                    end else if (r_armed && w_wrap) begin
                        r_armed   <= 1'b0;
                        r_state   <= S_ODUB;
                        r_led_rec <= 1'b1;
                    end
`else
                    end else if (bus.rec_btn) begin
                        r_wr_trk  <= bus.trk_sel;
                        r_state   <= S_ODUB;
                        r_led_rec <= 1'b1;
                    end
`endif
                end
                S_ODUB: begin
                    if (bus.play_btn) begin
                        r_trk_valid <= r_trk_valid | w_trk_bit;
                        r_state     <= S_IDLE;
                        r_led_rec   <= 1'b0;
                        r_led_play  <= 1'b0;
                    end else if (bus.rec_btn) begin
                        r_trk_valid <= r_trk_valid | w_trk_bit;
                        r_state     <= S_PLAY;
                        r_led_rec   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_led_rec  <= 1'b0;
                    r_led_play <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/loop_track_ctrl.md
Name: loop_track_ctrl

Overview:
- Multi-track loop recorder controller; parametrised successor to the single-track rec/play mode FSM.
- The first recording defines the loop length. Further recordings overdub onto a selected track while the loop plays back.
- Sits between the debounced button pulse logic and the per-track sample RAMs.
- Drives the shared RAM address, write/read strobes, the track-valid mask and the status LEDs.

Parameters:
- NUM_TRACKS, 4, number of loop tracks (1..16).
- ADDR_W, 14, sample address width; maximum loop length is 2**ADDR_W samples.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- sample_tick  input  1  one-cycle strobe per audio sample period.
- rec_btn  input  1  one-cycle rec/overdub toggle pulse.
- play_btn  input  1  one-cycle play/stop toggle pulse.
- clear_btn  input  1  one-cycle clear-all pulse; honoured only in S_IDLE.
- trk_sel  input  $clog2(NUM_TRACKS) (min 1)  track to record or overdub.
- addr  output  ADDR_W  current sample address, shared by all tracks.
- wr_en  output  1  write strobe to track wr_trk at addr.
- wr_trk  output  $clog2(NUM_TRACKS) (min 1)  track latched at record entry.
- rd_en  output  1  read strobe for all tracks at addr.
- trk_valid  output  NUM_TRACKS  bit i set once track i holds a completed take; used as mixer mask.
- loop_end  output  ADDR_W  last valid address of the loop.
- len_valid  output  1  loop length is defined.
- wrap  output  1  one-cycle pulse when addr wraps from loop_end to 0.
- led_rec  output  1  high in S_REC1 or S_ODUB.
- led_play  output  1  high in S_PLAY or S_ODUB.

Behaviour:
- States (in loop_pkg): S_IDLE, S_REC1 (first take), S_PLAY, S_ODUB.
- Reset (async) values:
  - state=S_IDLE, addr=0, loop_end=0, len_valid=0, trk_valid=0, wr_trk=0.
  - All strobes and LEDs low.
- Button priority in one cycle: play_btn > rec_btn. In S_IDLE, clear_btn > play_btn > rec_btn.
- S_IDLE:
  - addr held at 0.
  - clear -> len_valid=0, trk_valid=0, loop_end=0.
  - play with len_valid=1 -> S_PLAY; play with len_valid=0 is ignored.
  - rec with len_valid=0 -> S_REC1, latch wr_trk=trk_sel.
  - rec with len_valid=1 -> S_ODUB, latch wr_trk=trk_sel.
- S_REC1:
  - On each tick: wr_en=1 at the current addr, then addr+1.
  - Close on rec or play pulse. Sample count = addr, or addr+1 if a tick occurs in the same cycle.
  - count=0 -> back to S_IDLE, nothing stored.
  - count>0 -> loop_end=count-1, len_valid=1, trk_valid[wr_trk]=1, addr=0, -> S_PLAY.
  - Auto-close: a tick at addr=all-ones writes that sample, then loop_end=all-ones, close as above, -> S_PLAY.
- S_PLAY and S_ODUB address stepping:
  - On tick: rd_en=1. If addr==loop_end, then addr=0 and wrap=1; else addr+1.
- S_PLAY transitions:
  - play -> S_IDLE, addr=0.
  - rec -> S_ODUB, latch wr_trk=trk_sel; addr keeps running.
- S_ODUB:
  - On tick: rd_en=1 and wr_en=1 at the same addr.
  - rec -> S_PLAY, trk_valid[wr_trk]=1.
  - play -> S_IDLE, trk_valid[wr_trk]=1, addr=0.
- Strobe timing:
  - wr_en, rd_en and wrap are combinational from state, addr and sample_tick in the tick cycle.
  - The addr update is registered at that clock edge (zero latency).
- Other rules:
  - trk_sel changes mid-take have no effect.
  - wr_trk is stable for the whole take.

Optional Feature:
- LOOP_QUANT_EN defined:
  - In S_PLAY, a rec pulse is armed, not applied immediately.
  - The S_ODUB entry happens on the next wrap, so the overdub starts at addr 0.
  - A second rec pulse before the wrap disarms it.
  - A play pulse while armed stops and disarms.
- LOOP_QUANT_EN undefined: rec is applied immediately, as described in Behaviour.

Decomposition:
- loop_pkg holds:
  - the state_t enum;
  - a TRK_W function/localparam helper: $clog2 with minimum 1.
- Sub-module loop_addr_ctr: ADDR_W counter with inputs tick, clr, wrap_en and end value; outputs addr and wrap. Used for both first-take counting and loop wrapping.

Test Plan:
- Reset mid-S_ODUB (assert rst async between clock edges) -> all outputs return to reset values immediately, before the next clk edge.
- ADDR_W=4, rec, 5 ticks, rec -> loop_end=4, len_valid=1, trk_valid=0001, S_PLAY; 5 further ticks -> wrap on the 5th tick, addr=0.
- rec then immediate rec with no ticks -> back to S_IDLE, len_valid=0, trk_valid=0.
- ADDR_W=4, rec, 16 ticks -> auto-close with loop_end=15, S_PLAY, wrap after 16 further ticks.
- Loop of 5 defined; trk_sel=2, rec in S_PLAY at addr 3 -> wr_trk=2, wr_en and rd_en together on ticks; rec -> trk_valid=0101. In a LOOP_QUANT_EN build, wr_en first asserts at addr 0 after the wrap.
- clear_btn in S_PLAY -> ignored; play, then clear in S_IDLE -> len_valid=0, trk_valid=0; a subsequent play is ignored.
